// File: rtl/adder_result_checker_if.sv
// Operand stream seen by the adder result checker: operands issued to the adder,
// the adder's result, and the end-of-stream stop request.
interface adder_result_checker_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [DATA_W-1:0] dut_result;
  logic              stop;

  modport master (output in_valid, in_a, in_b, dut_result, stop);
  modport slave  (input  in_valid, in_a, in_b, dut_result, stop);
endinterface

// File: rtl/adder_result_checker.sv
// Scoreboard for the adder: rebuilds the expected sum of each operand pair, compares it
// with the adder result LATENCY cycles later and keeps pass/fail/first-failure state.
module adder_result_checker #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  adder_result_checker_if.slave  bus,
  output logic [CNT_W-1:0]       txn_cnt,
  output logic [CNT_W-1:0]       pass_cnt,
  output logic [CNT_W-1:0]       fail_cnt,
  output logic                   mismatch,
  output logic                   fail_seen,
  output logic [CNT_W-1:0]       fail_txn,
  output logic [DATA_W-1:0]      fail_exp,
  output logic [DATA_W-1:0]      fail_act,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] exp;
    logic [CNT_W-1:0]  idx;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state_q, state_d;
  logic   accept_c;
  entry_t acc_entry_c;
  entry_t cmp_c;
  logic   line_busy_c;
  logic   cmp_pass_c;
  logic   cmp_fail_c;

  // Operand acceptance and the expected sum (carry out is dropped by the width)
  always_comb begin
    accept_c        = bus.in_valid && ((state_q == IDLE) || (state_q == RUN));
    acc_entry_c.vld = accept_c;
    acc_entry_c.exp = bus.in_a + bus.in_b;
    acc_entry_c.idx = txn_cnt;
  end

  // Zero latency compares the entry being accepted; otherwise the tail of the delay line
  if (LATENCY == 0) begin : g_nodelay
    assign cmp_c       = acc_entry_c;
    assign line_busy_c = 1'b0;
  end else begin : g_delay
    entry_t line_q [LATENCY];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < int'(LATENCY); i++) line_q[i] <= '0;
      end else begin
        line_q[0] <= acc_entry_c;
        for (int i = 1; i < int'(LATENCY); i++) line_q[i] <= line_q[i-1];
      end
    end

    always_comb begin
      line_busy_c = 1'b0;
      for (int i = 0; i < int'(LATENCY); i++) line_busy_c = line_busy_c | line_q[i].vld;
    end

    assign cmp_c = line_q[LATENCY-1];
  end

  always_comb begin
    cmp_pass_c = cmp_c.vld && (cmp_c.exp == bus.dut_result);
    cmp_fail_c = cmp_c.vld && (cmp_c.exp != bus.dut_result);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.stop)          state_d = bus.in_valid ? DRAIN : DONE;
        else if (bus.in_valid) state_d = RUN;
      end
      RUN:     if (bus.stop) state_d = DRAIN;
      DRAIN:   if (!line_busy_c) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Saturating counters, first-failure capture and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txn_cnt   <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      mismatch  <= 1'b0;
      fail_seen <= 1'b0;
      fail_txn  <= '0;
      fail_exp  <= '0;
      fail_act  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (accept_c && (txn_cnt != CNT_MAX))   txn_cnt  <= txn_cnt + CNT_W'(1);
      if (cmp_pass_c && (pass_cnt != CNT_MAX)) pass_cnt <= pass_cnt + CNT_W'(1);
      if (cmp_fail_c && (fail_cnt != CNT_MAX)) fail_cnt <= fail_cnt + CNT_W'(1);
      mismatch <= cmp_fail_c;
      if (cmp_fail_c && !fail_seen) begin
        fail_seen <= 1'b1;
        fail_txn  <= cmp_c.idx;
        fail_exp  <= cmp_c.exp;
        fail_act  <= bus.dut_result;
      end
      busy <= (state_d == RUN) || (state_d == DRAIN);
      done <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench for adder_result_checker: four instances cover LATENCY 1/3/0 and a
// 4-bit counter build; every expectation is a hand-derived constant.
module tb_adder_result_checker;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  adder_result_checker_if #(.DATA_W(32)) bus1 ();
  adder_result_checker_if #(.DATA_W(32)) bus3 ();
  adder_result_checker_if #(.DATA_W(32)) bus0 ();
  adder_result_checker_if #(.DATA_W(32)) bus4 ();

  logic [15:0] txn1, pass1, fail1, ftxn1;
  logic [31:0] fexp1, fact1;
  logic        mm1, fseen1, busy1, done1;
  logic [15:0] txn3, pass3, fail3, ftxn3;
  logic [31:0] fexp3, fact3;
  logic        mm3, fseen3, busy3, done3;
  logic [15:0] txn0, pass0, fail0, ftxn0;
  logic [31:0] fexp0, fact0;
  logic        mm0, fseen0, busy0, done0;
  logic [3:0]  txn4, pass4, fail4, ftxn4;
  logic [31:0] fexp4, fact4;
  logic        mm4, fseen4, busy4, done4;

  adder_result_checker #(.DATA_W(32), .LATENCY(1), .CNT_W(16)) u_l1 (
    .clk(clk), .reset(reset), .bus(bus1), .txn_cnt(txn1), .pass_cnt(pass1), .fail_cnt(fail1),
    .mismatch(mm1), .fail_seen(fseen1), .fail_txn(ftxn1), .fail_exp(fexp1), .fail_act(fact1),
    .busy(busy1), .done(done1));

  adder_result_checker #(.DATA_W(32), .LATENCY(3), .CNT_W(16)) u_l3 (
    .clk(clk), .reset(reset), .bus(bus3), .txn_cnt(txn3), .pass_cnt(pass3), .fail_cnt(fail3),
    .mismatch(mm3), .fail_seen(fseen3), .fail_txn(ftxn3), .fail_exp(fexp3), .fail_act(fact3),
    .busy(busy3), .done(done3));

  adder_result_checker #(.DATA_W(32), .LATENCY(0), .CNT_W(16)) u_l0 (
    .clk(clk), .reset(reset), .bus(bus0), .txn_cnt(txn0), .pass_cnt(pass0), .fail_cnt(fail0),
    .mismatch(mm0), .fail_seen(fseen0), .fail_txn(ftxn0), .fail_exp(fexp0), .fail_act(fact0),
    .busy(busy0), .done(done0));

  adder_result_checker #(.DATA_W(32), .LATENCY(1), .CNT_W(4)) u_c4 (
    .clk(clk), .reset(reset), .bus(bus4), .txn_cnt(txn4), .pass_cnt(pass4), .fail_cnt(fail4),
    .mismatch(mm4), .fail_seen(fseen4), .fail_txn(ftxn4), .fail_exp(fexp4), .fail_act(fact4),
    .busy(busy4), .done(done4));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.dut_result = '0; bus1.stop = 1'b0;
    bus3.in_valid = 1'b0; bus3.in_a = '0; bus3.in_b = '0; bus3.dut_result = '0; bus3.stop = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_a = '0; bus0.in_b = '0; bus0.dut_result = '0; bus0.stop = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_a = '0; bus4.in_b = '0; bus4.dut_result = '0; bus4.stop = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    idle_all();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_all();
    #2;
    checks++; if (txn1 !== 16'd0)  begin errors++; $display("FAIL reset_txn: got %0d want 0", txn1); end
    checks++; if (pass1 !== 16'd0) begin errors++; $display("FAIL reset_pass: got %0d want 0", pass1); end
    checks++; if (fail1 !== 16'd0) begin errors++; $display("FAIL reset_fail: got %0d want 0", fail1); end
    checks++; if ({mm1, fseen1, busy1, done1} !== 4'b0000)
      begin errors++; $display("FAIL reset_flags: got %b want 0000", {mm1, fseen1, busy1, done1}); end
    tick();
    reset = 1'b0;
    // stop with nothing pending in IDLE goes straight to DONE
    bus1.stop = 1'b1;
    tick();
    bus1.stop = 1'b0;
    checks++; if ({busy1, done1} !== 2'b01)
      begin errors++; $display("FAIL idle_stop: got busy/done=%b want 01", {busy1, done1}); end
  endtask

  task automatic test_basic;
    do_reset();
    bus1.in_valid = 1'b1; bus1.in_a = 32'd5; bus1.in_b = 32'd2;
    tick();
    checks++; if (txn1 !== 16'd1) begin errors++; $display("FAIL basic_txn: got %0d want 1", txn1); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy1); end
    bus1.in_valid = 1'b0; bus1.dut_result = 32'd7;
    tick();
    checks++; if (pass1 !== 16'd1) begin errors++; $display("FAIL basic_pass: got %0d want 1", pass1); end
    checks++; if (fail1 !== 16'd0) begin errors++; $display("FAIL basic_fail: got %0d want 0", fail1); end
  endtask

  task automatic test_carry;
    logic [32:0] wide;
    wide = 33'h1_0000_0000;
    bus1.in_valid = 1'b1; bus1.in_a = 32'hFFFF_FFFF; bus1.in_b = 32'd1; bus1.dut_result = 32'd0;
    tick();                                  // txn 1 accepted
    bus1.dut_result = 32'd0;
    tick();                                  // txn 1 scored, txn 2 accepted
    bus1.dut_result = wide[31:0];
    tick();                                  // txn 2 scored, txn 3 accepted
    bus1.in_valid = 1'b0; bus1.dut_result = 32'd1;
    tick();                                  // txn 3 scored as a failure
    checks++; if (pass1 !== 16'd3) begin errors++; $display("FAIL carry_pass: got %0d want 3", pass1); end
    checks++; if (fail1 !== 16'd1) begin errors++; $display("FAIL carry_fail: got %0d want 1", fail1); end
    checks++; if (mm1 !== 1'b1) begin errors++; $display("FAIL carry_mismatch: got %b want 1", mm1); end
    checks++; if (ftxn1 !== 16'd3) begin errors++; $display("FAIL carry_fail_txn: got %0d want 3", ftxn1); end
    checks++; if (fexp1 !== 32'd0) begin errors++; $display("FAIL carry_fail_exp: got %h want 0", fexp1); end
    checks++; if (fact1 !== 32'd1) begin errors++; $display("FAIL carry_fail_act: got %h want 1", fact1); end
    bus1.dut_result = 32'd0;
    tick();
    checks++; if (mm1 !== 1'b0) begin errors++; $display("FAIL carry_pulse_end: got %b want 0", mm1); end
    checks++; if (fseen1 !== 1'b1) begin errors++; $display("FAIL carry_fail_seen: got %b want 1", fseen1); end
  endtask

  task automatic test_back_to_back;
    int pulses;
    logic [31:0] r;
    pulses = 0;
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      bus1.in_valid = (i < 10);
      bus1.in_a     = 32'(i * 3 + 1);
      bus1.in_b     = 32'(i * 100);
      r = 32'((i - 1) * 3 + 1 + (i - 1) * 100);
      if ((i == 3) || (i == 7)) r = r ^ 32'h10;
      bus1.dut_result = (i > 0) ? r : 32'd0;
      tick();
      if (mm1) pulses++;
    end
    bus1.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (mm1) pulses++;
    end
    checks++; if (pass1 !== 16'd8)  begin errors++; $display("FAIL b2b_pass: got %0d want 8", pass1); end
    checks++; if (fail1 !== 16'd2)  begin errors++; $display("FAIL b2b_fail: got %0d want 2", fail1); end
    checks++; if (txn1 !== 16'd10)  begin errors++; $display("FAIL b2b_txn: got %0d want 10", txn1); end
    checks++; if (pulses !== 2)     begin errors++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
    checks++; if (ftxn1 !== 16'd2)  begin errors++; $display("FAIL b2b_fail_txn: got %0d want 2", ftxn1); end
    checks++; if (fexp1 !== 32'd207) begin errors++; $display("FAIL b2b_fail_exp: got %0d want 207", fexp1); end
    checks++; if (fact1 !== 32'd223) begin errors++; $display("FAIL b2b_fail_act: got %0d want 223", fact1); end
  endtask

  task automatic test_saturation;
    do_reset();
    for (int i = 0; i <= 20; i++) begin
      bus4.in_valid   = (i < 20);
      bus4.in_a       = 32'(i);
      bus4.in_b       = 32'd7;
      bus4.dut_result = (i > 0) ? 32'(i - 1 + 7) : 32'd0;
      tick();
    end
    bus4.in_valid = 1'b0;
    checks++; if (pass4 !== 4'd15) begin errors++; $display("FAIL sat_pass: got %0d want 15", pass4); end
    checks++; if (txn4 !== 4'd15)  begin errors++; $display("FAIL sat_txn: got %0d want 15", txn4); end
    checks++; if (fail4 !== 4'd0)  begin errors++; $display("FAIL sat_fail: got %0d want 0", fail4); end
  endtask

  task automatic test_drain;
    do_reset();
    for (int t = 0; t <= 7; t++) begin
      bus3.in_valid   = 1'b1;
      bus3.in_a       = (t <= 4) ? 32'(t * 16) : 32'd100;
      bus3.in_b       = (t <= 4) ? 32'd1000 : 32'd100;
      bus3.stop       = (t == 4);
      bus3.dut_result = (t >= 3) ? 32'((t - 3) * 16 + 1000) : 32'd0;
      tick();
      if (t == 4) begin
        checks++; if (txn3 !== 16'd5) begin errors++; $display("FAIL drain_txn_at_stop: got %0d want 5", txn3); end
      end
    end
    bus3.stop = 1'b0;
    checks++; if ({busy3, done3} !== 2'b10)
      begin errors++; $display("FAIL drain_last_compare: got busy/done=%b want 10", {busy3, done3}); end
    checks++; if (pass3 !== 16'd5) begin errors++; $display("FAIL drain_pass: got %0d want 5", pass3); end
    bus3.in_valid = 1'b0;
    tick();
    checks++; if ({busy3, done3} !== 2'b01)
      begin errors++; $display("FAIL drain_done: got busy/done=%b want 01", {busy3, done3}); end
    checks++; if (txn3 !== 16'd5) begin errors++; $display("FAIL drain_ignored_txn: got %0d want 5", txn3); end
    tick();
    tick();
    checks++; if (done3 !== 1'b1) begin errors++; $display("FAIL done_sticky: got %b want 1", done3); end
  endtask

  task automatic test_reset_inflight;
    do_reset();
    bus3.in_valid = 1'b1; bus3.in_a = 32'd1; bus3.in_b = 32'd2;
    tick();
    bus3.in_a = 32'd3; bus3.in_b = 32'd4;
    tick();
    bus3.in_valid = 1'b0; bus3.dut_result = 32'hDEAD;
    #1 reset = 1'b1;
    #1;
    checks++; if (txn3 !== 16'd0) begin errors++; $display("FAIL async_reset_txn: got %0d want 0", txn3); end
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b want 0", busy3); end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++; if ({pass3, fail3} !== 32'd0)
      begin errors++; $display("FAIL flushed_scores: got pass=%0d fail=%0d want 0/0", pass3, fail3); end
    bus3.in_valid = 1'b1; bus3.in_a = 32'd1; bus3.in_b = 32'd1; bus3.dut_result = 32'd5;
    tick();
    bus3.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (fail3 !== 16'd1) begin errors++; $display("FAIL post_reset_fail: got %0d want 1", fail3); end
    checks++; if (ftxn3 !== 16'd0) begin errors++; $display("FAIL post_reset_idx: got %0d want 0", ftxn3); end
    checks++; if ({fexp3, fact3} !== {32'd2, 32'd5})
      begin errors++; $display("FAIL post_reset_vals: got exp=%0d act=%0d want 2/5", fexp3, fact3); end
  endtask

  task automatic test_latency0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus0.in_valid   = 1'b1;
      bus0.in_a       = 32'(i + 10);
      bus0.in_b       = 32'(i * 2);
      bus0.dut_result = 32'(i + 10 + i * 2);
      tick();
      if (i == 0) begin
        checks++; if (pass0 !== 16'd1) begin errors++; $display("FAIL lat0_first: got %0d want 1", pass0); end
      end
    end
    bus0.in_valid = 1'b0; bus0.stop = 1'b1;
    tick();
    bus0.stop = 1'b0;
    checks++; if ({busy0, done0} !== 2'b10)
      begin errors++; $display("FAIL lat0_drain: got busy/done=%b want 10", {busy0, done0}); end
    tick();
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL lat0_done: got %b want 1", done0); end
    checks++; if ({txn0, pass0, fail0} !== {16'd4, 16'd4, 16'd0})
      begin errors++; $display("FAIL lat0_counts: got txn=%0d pass=%0d fail=%0d want 4/4/0", txn0, pass0, fail0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_saturation();
    test_drain();
    test_reset_inflight();
    test_latency0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
